mem_stage_dm: RTL and testbench



---
 rtl/mips_pkg.sv | 56 +++++
 rtl/dm_ram.sv | 37 +++
 rtl/mem_stage_dm.sv | 141 ++++++++++++++
 tb/tb_mem_stage_dm.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS data-memory definitions: memory opcodes, lane sizes, the
// decoded memory-op record and the byte-lane merge helper.
package mips_pkg;

    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SB  = 6'b101000;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } lane_size_e;

    typedef struct packed {
        logic       is_load;
        logic       is_store;
        lane_size_e size;
        logic       ext_sign;
    } mem_op_t;

    // Classify an opcode; non-memory opcodes come back with both flags low.
    function automatic mem_op_t decode_op(input logic [5:0] opcode);
        mem_op_t op;
        op = '{is_load: 1'b0, is_store: 1'b0, size: SZ_W, ext_sign: 1'b0};
        case (opcode)
            OP_LW:   op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_W, ext_sign: 1'b0};
            OP_LH:   op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_H, ext_sign: 1'b1};
            OP_LHU:  op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_H, ext_sign: 1'b0};
            OP_LB:   op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_B, ext_sign: 1'b1};
            OP_LBU:  op = '{is_load: 1'b1, is_store: 1'b0, size: SZ_B, ext_sign: 1'b0};
            OP_SW:   op = '{is_load: 1'b0, is_store: 1'b1, size: SZ_W, ext_sign: 1'b0};
            OP_SH:   op = '{is_load: 1'b0, is_store: 1'b1, size: SZ_H, ext_sign: 1'b0};
            OP_SB:   op = '{is_load: 1'b0, is_store: 1'b1, size: SZ_B, ext_sign: 1'b0};
            default: op = '{is_load: 1'b0, is_store: 1'b0, size: SZ_W, ext_sign: 1'b0};
        endcase
        return op;
    endfunction

    // Replace only the enabled byte lanes of old_word with new_word.
    function automatic logic [31:0] merge_word(input logic [31:0] old_word,
                                               input logic [31:0] new_word,
                                               input logic [3:0]  be);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = be[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/dm_ram.sv
// Word-organised data RAM: synchronous whole-array clear, byte-lane write,
// asynchronous read.
module dm_ram
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [3:0]        be,
    input  logic [ADDR_W-1:0] idx,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] word_s [DEPTH];

    for (genvar g = 0; g < DEPTH; g++) begin : g_word
        logic [31:0] word_r;

        // Clear on reset (reset wins over a concurrent store), else merge enabled lanes.
        always_ff @(posedge clk) begin
            if (reset) begin
                word_r <= 32'd0;
            end else if (we && (idx == ADDR_W'(g))) begin
                word_r <= merge_word(word_r, wdata, be);
            end
        end

        assign word_s[g] = word_r;
    end

    assign rdata = word_s[idx];

endmodule

// File: rtl/mem_stage_dm.sv
// MEM-stage data-memory unit: load/store decode, lane steering, load
// extension, alignment check and write-back select. All outputs are
// combinational in the EX/MEM register outputs; only the RAM holds state.
// Optional: define DM_TRACE_EN to print every committed RAM write.
module mem_stage_dm
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_m,
    input  logic [31:0] instr_m,
    input  logic [4:0]  a3_m,
    input  logic [31:0] wd_in_m,
    input  logic [31:0] rd2_m,
    output logic [31:0] wd_out_m,
    output logic [4:0]  a3_out_m,
    output logic [31:0] ld_data_m,
    output logic        mem_we,
    output logic [3:0]  byte_en,
    output logic        misalign
);

    mem_op_t           op_s;
    logic [1:0]        addr_lo_s;
    logic [ADDR_W-1:0] idx_s;
    logic              misalign_s;
    logic              we_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic [31:0]       rdata_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic [31:0]       ext_s;
    logic              unused_s;

    assign op_s      = decode_op(instr_m[31:26]);
    assign addr_lo_s = wd_in_m[1:0];
    // Upper address bits are dropped on purpose: accesses wrap modulo DEPTH*4.
    assign idx_s     = wd_in_m[ADDR_W+1:2];
    assign unused_s  = ^{pc_m, instr_m[25:0]};

    // Natural-alignment check, only meaningful for memory ops.
    always_comb begin
        misalign_s = 1'b0;
        if (op_s.is_load || op_s.is_store) begin
            case (op_s.size)
                SZ_W:    misalign_s = (addr_lo_s != 2'b00);
                SZ_H:    misalign_s = addr_lo_s[0];
                SZ_B:    misalign_s = 1'b0;
                default: misalign_s = 1'b0;
            endcase
        end else begin
            misalign_s = 1'b0;
        end
    end

    // Store lane steering; misaligned stores are suppressed entirely.
    always_comb begin
        we_s    = 1'b0;
        be_s    = 4'b0000;
        wdata_s = 32'd0;
        if (op_s.is_store && !misalign_s) begin
            we_s = 1'b1;
            case (op_s.size)
                SZ_W: begin
                    be_s    = 4'b1111;
                    wdata_s = rd2_m;
                end
                SZ_H: begin
                    be_s    = addr_lo_s[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {2{rd2_m[15:0]}};
                end
                SZ_B: begin
                    be_s    = 4'b0001 << addr_lo_s;
                    wdata_s = {4{rd2_m[7:0]}};
                end
                default: begin
                    we_s    = 1'b0;
                    be_s    = 4'b0000;
                    wdata_s = 32'd0;
                end
            endcase
        end else begin
            we_s    = 1'b0;
            be_s    = 4'b0000;
            wdata_s = 32'd0;
        end
    end

    dm_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .be    (be_s),
        .idx   (idx_s),
        .wdata (wdata_s),
        .rdata (rdata_s)
    );

    // Lane select and sign/zero extension of the read word.
    always_comb begin
        case (addr_lo_s)
            2'd0:    byte_s = rdata_s[7:0];
            2'd1:    byte_s = rdata_s[15:8];
            2'd2:    byte_s = rdata_s[23:16];
            2'd3:    byte_s = rdata_s[31:24];
            default: byte_s = 8'd0;
        endcase
        half_s = addr_lo_s[1] ? rdata_s[31:16] : rdata_s[15:0];
        case (op_s.size)
            SZ_W:    ext_s = rdata_s;
            SZ_H:    ext_s = {{16{op_s.ext_sign & half_s[15]}}, half_s};
            SZ_B:    ext_s = {{24{op_s.ext_sign & byte_s[7]}}, byte_s};
            default: ext_s = 32'd0;
        endcase
    end

    assign ld_data_m = op_s.is_load ? ext_s : 32'd0;
    assign wd_out_m  = op_s.is_load ? ext_s : wd_in_m;
    assign a3_out_m  = a3_m;
    assign mem_we    = we_s;
    assign byte_en   = be_s;
    assign misalign  = misalign_s;

`ifdef DM_TRACE_EN
    // Report each committed write with the full merged word.
    always_ff @(posedge clk) begin
        if (!reset && we_s) begin
            $display("%d@%h: *%h <= %h", $time, pc_m, {wd_in_m[31:2], 2'b00},
                     merge_word(rdata_s, wdata_s, be_s));
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_dm.sv
// Bench for mem_stage_dm: directed scenarios plus randomized traffic checked
// against a byte-addressed memory model.
module tb_mem_stage_dm;

    localparam int DEPTH = 4096;
    localparam int NB    = DEPTH * 4;

    localparam logic [5:0] LW = 6'b100011, LH = 6'b100001, LHU = 6'b100101;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100;
    localparam logic [5:0] SW = 6'b101011, SH = 6'b101001, SB = 6'b101000;
    localparam logic [5:0] ADDI = 6'b001000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_m, instr_m, wd_in_m, rd2_m;
    logic [4:0]  a3_m;
    logic [31:0] wd_out_m, ld_data_m;
    logic [4:0]  a3_out_m;
    logic        mem_we, misalign;
    logic [3:0]  byte_en;

    int total = 0;
    int bad   = 0;
    logic [7:0] mb [NB];

    mem_stage_dm #(.DEPTH(DEPTH), .ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .pc_m(pc_m), .instr_m(instr_m), .a3_m(a3_m),
        .wd_in_m(wd_in_m), .rd2_m(rd2_m), .wd_out_m(wd_out_m), .a3_out_m(a3_out_m),
        .ld_data_m(ld_data_m), .mem_we(mem_we), .byte_en(byte_en), .misalign(misalign)
    );

    always #5 clk = ~clk;

    // Access size in bytes, 0 for non-memory opcodes.
    function automatic int op_bytes(input logic [5:0] op);
        if (op == LW || op == SW) return 4;
        if (op == LH || op == LHU || op == SH) return 2;
        if (op == LB || op == LBU || op == SB) return 1;
        return 0;
    endfunction

    function automatic bit op_store(input logic [5:0] op);
        return (op == SW || op == SH || op == SB);
    endfunction

    function automatic bit op_load(input logic [5:0] op);
        return (op_bytes(op) != 0) && !op_store(op);
    endfunction

    function automatic bit op_aligned(input logic [5:0] op, input logic [31:0] addr);
        int n;
        n = op_bytes(op);
        if (n == 0) return 1'b1;
        return (addr % n) == 0;
    endfunction

    // Value a load returns: bytes from the naturally aligned base, little-endian.
    function automatic logic [31:0] model_load(input logic [5:0] op, input logic [31:0] addr);
        int n;
        int base;
        logic [31:0] v;
        n = op_bytes(op);
        base = int'(addr % NB);
        base = base - (base % n);
        v = 32'd0;
        for (int k = 0; k < n; k++) v = v | (32'(mb[base + k]) << (8 * k));
        if (op == LB && v[7]) v = v | 32'hFFFFFF00;
        if (op == LH && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [5:0] op, input logic [31:0] addr);
        logic [3:0] be;
        be = 4'b0000;
        if (op_store(op) && op_aligned(op, addr))
            for (int k = 0; k < op_bytes(op); k++) be[(addr % 4) + k] = 1'b1;
        return be;
    endfunction

    task automatic model_store(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] data);
        if (op_store(op) && op_aligned(op, addr))
            for (int k = 0; k < op_bytes(op); k++) mb[(addr + k) % NB] = 8'(data >> (8 * k));
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] r;
        r = $urandom;
        instr_m = instr;
        wd_in_m = addr;
        rd2_m   = data;
        a3_m    = r[4:0];
        pc_m    = pc_m + 32'd4;
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [5:0] op);
        return {op, 26'h0A5F3C1};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; instr_m = 32'd0; wd_in_m = 32'd0; rd2_m = 32'd0; a3_m = 5'd0; pc_m = 32'd0;
        step(); step();
        total++; if (wd_out_m !== 32'd0) begin bad++; $display("FAIL reset_wd_out got=%h want=0", wd_out_m); end
        total++; if (a3_out_m !== 5'd0) begin bad++; $display("FAIL reset_a3_out got=%h want=0", a3_out_m); end
        total++; if ({mem_we, byte_en, misalign} !== 6'd0) begin bad++; $display("FAIL reset_ctrl got=%b want=0", {mem_we, byte_en, misalign}); end
        total++; if (ld_data_m !== 32'd0) begin bad++; $display("FAIL reset_ld_data got=%h want=0", ld_data_m); end
        reset = 1'b0;
        drive(mk(LW), 32'h100, 32'd0);
        total++; if (ld_data_m !== 32'd0) begin bad++; $display("FAIL reset_ram_clear got=%h want=0", ld_data_m); end
    endtask

    task automatic test_sw_lw();
        drive(mk(SW), 32'h10, 32'h12345678);
        total++; if ({mem_we, byte_en, misalign} !== 6'b111110) begin bad++; $display("FAIL sw_ctrl got=%b want=111110", {mem_we, byte_en, misalign}); end
        total++; if (wd_out_m !== 32'h10) begin bad++; $display("FAIL sw_wd_out got=%h want=10", wd_out_m); end
        step();
        drive(mk(LW), 32'h10, 32'h0);
        total++; if (ld_data_m !== 32'h12345678) begin bad++; $display("FAIL lw_data got=%h want=12345678", ld_data_m); end
        total++; if (wd_out_m !== 32'h12345678) begin bad++; $display("FAIL lw_wd_out got=%h want=12345678", wd_out_m); end
        total++; if (a3_out_m !== a3_m) begin bad++; $display("FAIL a3_pass got=%h want=%h", a3_out_m, a3_m); end
    endtask

    task automatic test_sb();
        drive(mk(SB), 32'h13, 32'hCDEF12AB);
        total++; if (byte_en !== 4'b1000) begin bad++; $display("FAIL sb_be got=%b want=1000", byte_en); end
        step();
        drive(mk(LW), 32'h10, 32'h0);
        total++; if (ld_data_m !== 32'hAB345678) begin bad++; $display("FAIL sb_word got=%h want=ab345678", ld_data_m); end
        drive(mk(LB), 32'h13, 32'h0);
        total++; if (ld_data_m !== 32'hFFFFFFAB) begin bad++; $display("FAIL lb got=%h want=ffffffab", ld_data_m); end
        drive(mk(LBU), 32'h13, 32'h0);
        total++; if (ld_data_m !== 32'h000000AB) begin bad++; $display("FAIL lbu got=%h want=000000ab", ld_data_m); end
    endtask

    task automatic test_sh();
        drive(mk(SH), 32'h12, 32'h77778001);
        total++; if (byte_en !== 4'b1100) begin bad++; $display("FAIL sh_be got=%b want=1100", byte_en); end
        step();
        drive(mk(LW), 32'h10, 32'h0);
        total++; if (ld_data_m !== 32'h80015678) begin bad++; $display("FAIL sh_word got=%h want=80015678", ld_data_m); end
        drive(mk(LH), 32'h12, 32'h0);
        total++; if (ld_data_m !== 32'hFFFF8001) begin bad++; $display("FAIL lh got=%h want=ffff8001", ld_data_m); end
        drive(mk(LHU), 32'h12, 32'h0);
        total++; if (ld_data_m !== 32'h00008001) begin bad++; $display("FAIL lhu got=%h want=00008001", ld_data_m); end
    endtask

    task automatic test_misalign();
        drive(mk(SW), 32'h20, 32'hCAFEF00D);
        step();
        drive(mk(SW), 32'h21, 32'h11111111);
        total++; if ({mem_we, byte_en, misalign} !== 6'b000001) begin bad++; $display("FAIL misalign_sw got=%b want=000001", {mem_we, byte_en, misalign}); end
        step();
        drive(mk(LW), 32'h20, 32'h0);
        total++; if (ld_data_m !== 32'hCAFEF00D) begin bad++; $display("FAIL misalign_unchanged got=%h want=cafef00d", ld_data_m); end
        drive(mk(LW), 32'h22, 32'h0);
        total++; if ({misalign, ld_data_m} !== {1'b1, 32'hCAFEF00D}) begin bad++; $display("FAIL misalign_lw got=%b/%h want=1/cafef00d", misalign, ld_data_m); end
        drive(mk(LH), 32'h13, 32'h0);
        total++; if ({misalign, ld_data_m} !== {1'b1, 32'hFFFF8001}) begin bad++; $display("FAIL misalign_lh got=%b/%h want=1/ffff8001", misalign, ld_data_m); end
        drive(mk(ADDI), 32'h55, 32'h99);
        total++; if ({wd_out_m, ld_data_m} !== {32'h55, 32'h0}) begin bad++; $display("FAIL addi got=%h/%h want=55/0", wd_out_m, ld_data_m); end
        total++; if ({mem_we, byte_en, misalign} !== 6'd0) begin bad++; $display("FAIL addi_ctrl got=%b want=0", {mem_we, byte_en, misalign}); end
    endtask

    task automatic test_wrap();
        drive(mk(SW), 32'h4000, 32'hDEADBEEF);
        step();
        drive(mk(LW), 32'h0, 32'h0);
        total++; if (ld_data_m !== 32'hDEADBEEF) begin bad++; $display("FAIL wrap got=%h want=deadbeef", ld_data_m); end
    endtask

    task automatic test_reset_store();
        drive(mk(SW), 32'h8, 32'hFF);
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(mk(LW), 32'h8, 32'h0);
        total++; if (ld_data_m !== 32'd0) begin bad++; $display("FAIL reset_store_dropped got=%h want=0", ld_data_m); end
        drive(mk(LW), 32'h10, 32'h0);
        total++; if (ld_data_m !== 32'd0) begin bad++; $display("FAIL reset_clear_10 got=%h want=0", ld_data_m); end
        drive(mk(LW), 32'h0, 32'h0);
        total++; if (ld_data_m !== 32'd0) begin bad++; $display("FAIL reset_clear_0 got=%h want=0", ld_data_m); end
    endtask

    task automatic test_random();
        logic [5:0]  ops [11] = '{LW, LH, LHU, LB, LBU, SW, SH, SB, ADDI, 6'b000000, 6'b000010};
        logic [5:0]  op;
        logic [31:0] instr, addr, data, exp_ld, exp_wd, hi;
        bit st;
        for (int i = 0; i < NB; i++) mb[i] = 8'd0;
        for (int it = 0; it < 400; it++) begin
            op   = ops[$urandom_range(0, 10)];
            hi   = $urandom;
            addr = 32'($urandom_range(0, 63)) | (($urandom_range(0, 3) == 0) ? (hi & 32'hFFFFC000) : 32'd0);
            data = $urandom;
            instr = mk(op);
            if (op == 6'b000000 && $urandom_range(0, 1) == 1) instr = 32'd0;
            drive(instr, addr, data);
            st     = op_store(op);
            exp_ld = op_load(op) ? model_load(op, addr) : 32'd0;
            exp_wd = op_load(op) ? exp_ld : addr;
            total++; if (ld_data_m !== exp_ld) begin bad++; $display("FAIL rnd_ld it=%0d op=%b addr=%h got=%h want=%h", it, op, addr, ld_data_m, exp_ld); end
            total++; if (wd_out_m !== exp_wd) begin bad++; $display("FAIL rnd_wd it=%0d op=%b addr=%h got=%h want=%h", it, op, addr, wd_out_m, exp_wd); end
            total++; if (byte_en !== model_be(op, addr) || mem_we !== (st && op_aligned(op, addr))) begin
                bad++; $display("FAIL rnd_we it=%0d op=%b addr=%h got=%b/%b want=%b/%b", it, op, addr, mem_we, byte_en, st && op_aligned(op, addr), model_be(op, addr));
            end
            total++; if (misalign !== !op_aligned(op, addr)) begin bad++; $display("FAIL rnd_misalign it=%0d op=%b addr=%h got=%b", it, op, addr, misalign); end
            step();
            model_store(op, addr, data);
        end
    endtask

    initial begin
        test_reset();
        test_sw_lw();
        test_sb();
        test_sh();
        test_misalign();
        test_wrap();
        test_reset_store();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
